addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 121 ++++++++++++
 tb/tb_addsub_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: valid/ready pipelined unsigned add/subtract with signed
// W+1 bit result, overflow flag and optional saturation.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             sync flush of all stage valid bits
//   in_valid/ready  operand handshake (aIn, bIn, mode)
//   mode            0 = A-B, 1 = A+B
//   out_valid/ready result handshake (resOut, ovf)
module addsub_pipe #(
  parameter int W   = 4,
  parameter int LAT = 4,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] aIn,
  input  logic [W-1:0] bIn,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   resOut,
  output logic         ovf
);

  logic [LAT:1] v_q;
  logic [LAT:1] v_d;
  logic [LAT:1] rdy;
  logic [LAT:1] take;

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         m_q;

  logic [W:0]   res_q [2:LAT];
  logic [LAT:2] ov_q;

  logic signed [W+1:0] ax;
  logic signed [W+1:0] bx;
  logic signed [W+1:0] sum;
  logic [W:0]          res_d;
  logic                ovf_d;
  logic                acc;

  // Stage i can load when it is empty or some
  // downstream stage (or the sink) frees a slot.
  always_comb begin
    acc  = out_ready;
    rdy  = '0;
    take = '0;
    v_d  = v_q;
    for (int i = LAT; i >= 1; i--) begin
      acc    = acc || !v_q[i];
      rdy[i] = acc;
    end
    take[1] = in_valid && rdy[1] && !clr;
    for (int i = 2; i <= LAT; i++) begin
      take[i] = v_q[i-1] && rdy[i];
    end
    if (clr) begin
      v_d = '0;
    end else begin
      if (rdy[1]) v_d[1] = in_valid;
      for (int i = 2; i <= LAT; i++) begin
        if (rdy[i]) v_d[i] = v_q[i-1];
      end
    end
  end

  // Only positive overflow is reachable, so
  // saturation always clamps to 2^W-1.
  always_comb begin
    ax    = signed'({2'b00, a_q});
    bx    = signed'({2'b00, b_q});
    sum   = m_q ? (ax + bx) : (ax - bx);
    ovf_d = sum[W+1] ^ sum[W];
    res_d = sum[W:0];
    if ((SAT != 0) && ovf_d) begin
      res_d = {1'b0, {W{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= 1'b0;
      ov_q <= '0;
      for (int i = 2; i <= LAT; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      if (take[1]) begin
        a_q <= aIn;
        b_q <= bIn;
        m_q <= mode;
      end
      if (take[2]) begin
        res_q[2] <= res_d;
        ov_q[2]  <= ovf_d;
      end
      for (int i = 3; i <= LAT; i++) begin
        if (take[i]) begin
          res_q[i] <= res_q[i-1];
          ov_q[i]  <= ov_q[i-1];
        end
      end
    end
  end

  assign in_ready  = rdy[1] && !clr;
  assign out_valid = v_q[LAT];
  assign resOut    = res_q[LAT];
  assign ovf       = ov_q[LAT];

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and scoreboard checks for addsub_pipe
// (W4/LAT4 wrap + saturate, W8/LAT2 random).
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       iv, m, ordy;
  logic [3:0] a, b;
  logic       ir0, ov0, of0;
  logic [4:0] r0;
  logic       ir1, ov1, of1;
  logic [4:0] r1;

  logic       iv8, m8, or8;
  logic [7:0] a8, b8;
  logic       ir8, ov8, of8;
  logic [8:0] r8;

  int checks = 0;
  int failures = 0;

  addsub_pipe #(.W(4), .LAT(4), .SAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(iv), .in_ready(ir0),
    .aIn(a), .bIn(b), .mode(m),
    .out_valid(ov0), .out_ready(ordy),
    .resOut(r0), .ovf(of0));

  addsub_pipe #(.W(4), .LAT(4), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(iv), .in_ready(ir1),
    .aIn(a), .bIn(b), .mode(m),
    .out_valid(ov1), .out_ready(ordy),
    .resOut(r1), .ovf(of1));

  addsub_pipe #(.W(8), .LAT(2), .SAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(iv8), .in_ready(ir8),
    .aIn(a8), .bIn(b8), .mode(m8),
    .out_valid(ov8), .out_ready(or8),
    .resOut(r8), .ovf(of8));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic vec(input string tag,
                     input logic [3:0] va, vb,
                     input logic vm,
                     input logic [4:0] e0, input logic o0,
                     input logic [4:0] e1, input logic o1);
    a = va; b = vb; m = vm; iv = 1'b1; ordy = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    tick();
    #1 chk({tag, "_early"}, ov0, 0);
    tick();
    #1;
    chk({tag, "_vld"}, ov0, 1);
    chk({tag, "_res0"}, r0, e0);
    chk({tag, "_ovf0"}, of0, o0);
    chk({tag, "_res1"}, r1, e1);
    chk({tag, "_ovf1"}, of1, o1);
    tick();
  endtask

  logic [9:0] q[$];
  logic [9:0] ref_v;
  int nxt, expn, full;
  logic [31:0] fv;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    iv = 0; a = 0; b = 0; m = 0; ordy = 1;
    iv8 = 0; a8 = 0; b8 = 0; m8 = 0; or8 = 1;
    tick();
    #1;
    chk("rst_vld", ov0, 0);
    chk("rst_res", r0, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_ovf", of0, 0);
    chk("rst_inrdy", ir0, 1);

    vec("sub3_9", 4'd3, 4'd9, 1'b0, 5'b11010, 0, 5'b11010, 0);
    vec("add15_15", 4'd15, 4'd15, 1'b1, 5'b11110, 1, 5'b01111, 1);
    vec("sub0_15", 4'd0, 4'd15, 1'b0, 5'b10001, 0, 5'b10001, 0);
    vec("add8_8", 4'd8, 4'd8, 1'b1, 5'b10000, 1, 5'b01111, 1);
    vec("add7_8", 4'd7, 4'd8, 1'b1, 5'b01111, 0, 5'b01111, 0);
    vec("sub5_5", 4'd5, 4'd5, 1'b0, 5'b00000, 0, 5'b00000, 0);

    // stall: inputs 1..10, out_ready low cycles 6-11
    nxt = 1; expn = 1;
    for (int k = 1; k <= 24; k++) begin
      iv = (nxt <= 10);
      a = nxt[3:0]; b = 4'd0; m = 1'b1;
      ordy = !(k >= 6 && k <= 11);
      #1;
      if (k >= 6 && k <= 11) chk("stall_inrdy", ir0, 0);
      if (k == 11) chk("stall_held", (nxt - 1) - (expn - 1), 4);
      if (k >= 12 && k <= 20) chk("no_gap", ov0, 1);
      if (ov0 && ordy) begin
        chk("order", r0, expn);
        expn++;
      end
      if (iv && ir0) nxt++;
      tick();
    end
    chk("all_out", expn, 11);
    iv = 0; ordy = 1;
    tick();

    // flush with three pairs in flight
    for (int k = 1; k <= 10; k++) begin
      iv = (k <= 5);
      a = (k == 5) ? 4'd7 : 4'(k);
      b = 4'd0; m = 1'b1;
      clr = (k == 4);
      #1;
      if (k == 4) chk("clr_inrdy", ir0, 0);
      if ((k >= 4 && k <= 8) || k == 10) chk("clr_flush", ov0, 0);
      if (k == 9) begin
        chk("clr_vld", ov0, 1);
        chk("clr_res", r0, 5'd7);
      end
      tick();
    end
    clr = 0; iv = 0;
    tick();

    // asynchronous reset mid-stream
    for (int k = 1; k <= 6; k++) begin
      iv = 1; a = 4'(k); b = 4'd0; m = 1'b1;
      #1;
      if (k == 6) chk("pre_rst_vld", ov0, 1);
      if (k < 6) tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vld", ov0, 0);
    chk("arst_res", r0, 0);
    chk("arst_ovf", of0, 0);
    iv = 0;
    tick();
    #2 rst_n = 1'b1;
    #1 chk("post_rst_inrdy", ir0, 1);
    a = 4'd11; b = 4'd0; m = 1'b1; iv = 1;
    tick();
    iv = 0;
    for (int j = 1; j <= 6; j++) begin
      #1;
      if (j == 4) begin
        chk("resume_vld", ov0, 1);
        chk("resume_res", r0, 5'd11);
      end else begin
        chk("resume_idle", ov0, 0);
      end
      tick();
    end

    // W=8 LAT=2 random scoreboard
    for (int k = 0; k < 300; k++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      m8 = 1'($urandom);
      or8 = ($urandom_range(0, 2) != 0);
      #1;
      if (ov8 && or8) begin
        if (q.size() == 0) chk("sb_extra", 1, 0);
        else chk("sb", {of8, r8}, q.pop_front());
      end
      if (iv8 && ir8) begin
        full = m8 ? (int'(a8) + int'(b8)) : (int'(a8) - int'(b8));
        fv = full;
        ref_v = {(full > 255 || full < -256), fv[8:0]};
        q.push_back(ref_v);
      end
      tick();
    end
    iv8 = 0; or8 = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (ov8) begin
        if (q.size() == 0) chk("sb_extra", 1, 0);
        else chk("sb_drain", {of8, r8}, q.pop_front());
      end
      tick();
    end
    chk("sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
